// File: rtl/re_prog_banks.sv
// Banked, programmable reflector: each bank holds an involutive letter pairing that
// translates one letter per cycle, can be re-plugged pair by pair, and can be scanned.
module re_prog_banks #(
    parameter int ALPHABET_LEN = 26,
    parameter int PORTLEN      = 5,
    parameter int NUM_BANKS    = 2,
    parameter int BANK_W       = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               re_cs_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PORTLEN-1:0] input_letter,
    input  logic [BANK_W-1:0]  bank_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PORTLEN-1:0] output_letter,
    output logic               error,
    input  logic               prog_valid,
    output logic               prog_ready,
    input  logic [BANK_W-1:0]  prog_bank,
    input  logic [PORTLEN-1:0] prog_a,
    input  logic [PORTLEN-1:0] prog_b,
    output logic               prog_err,
    input  logic               chk_start,
    input  logic [BANK_W-1:0]  chk_bank,
    output logic               chk_busy,
    output logic               chk_done,
    output logic               chk_ok
);

    localparam int LETTER_SPAN = 1 << PORTLEN;
    localparam int BANK_SPAN   = 1 << BANK_W;
    // One bit per encodable code: set when that letter / bank index actually exists.
    localparam logic [LETTER_SPAN-1:0] LETTER_OK = {LETTER_SPAN{1'b1}} >> (LETTER_SPAN - ALPHABET_LEN);
    localparam logic [BANK_SPAN-1:0]   BANK_OK   = {BANK_SPAN{1'b1}} >> (BANK_SPAN - NUM_BANKS);
    localparam logic [PORTLEN-1:0]     LAST_IDX  = PORTLEN'(ALPHABET_LEN - 1);

    typedef enum logic [1:0] {IDLE, PRG_RD, PRG_WR, CHK} state_t;

    state_t             state_q, state_d;
    logic [PORTLEN-1:0] lut_q [NUM_BANKS][ALPHABET_LEN];

    logic               out_valid_q, error_q;
    logic [PORTLEN-1:0] out_letter_q;
    logic [BANK_W-1:0]  prg_bank_q, chk_bank_q;
    logic [PORTLEN-1:0] prg_a_q, prg_b_q, pa_q, pb_q, idx_q;
    logic               rej_q, fail_q, chk_done_q, chk_ok_q;

    function automatic logic [PORTLEN-1:0] lut_rd(input logic [BANK_W-1:0] bk,
                                                  input logic [PORTLEN-1:0] ix);
        if (!BANK_OK[bk] || !LETTER_OK[ix]) return '0;
        else return lut_q[bk][ix];
    endfunction

    // Both handshakes transfer on a cycle where valid and ready are high together;
    // valid must not depend on ready, and a presented result holds until taken.
    logic in_acc, prog_acc, chk_go;
    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign prog_ready = (state_q == IDLE);
    assign in_acc     = in_valid && in_ready;
    assign prog_acc   = prog_valid && prog_ready;
    assign chk_go     = (state_q == IDLE) && chk_start && !prog_acc;

    logic               rej_d, ent_fail, last_idx;
    logic [PORTLEN-1:0] ent_v;
    assign rej_d    = !BANK_OK[prg_bank_q] || !LETTER_OK[prg_a_q] || !LETTER_OK[prg_b_q]
                      || (prg_a_q == prg_b_q);
    assign ent_v    = lut_rd(chk_bank_q, idx_q);
    assign ent_fail = !BANK_OK[chk_bank_q] || (ent_v == idx_q) || !LETTER_OK[ent_v]
                      || (lut_rd(chk_bank_q, ent_v) != idx_q);
    assign last_idx = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (prog_acc)    state_d = PRG_RD;
                else if (chk_go) state_d = CHK;
            end
            PRG_RD:  state_d = PRG_WR;
            PRG_WR:  state_d = IDLE;
            CHK:     if (last_idx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_letter_q <= '0;
            error_q      <= 1'b0;
            prg_bank_q   <= '0;
            prg_a_q      <= '0;
            prg_b_q      <= '0;
            pa_q         <= '0;
            pb_q         <= '0;
            rej_q        <= 1'b0;
            chk_bank_q   <= '0;
            idx_q        <= '0;
            fail_q       <= 1'b0;
            chk_done_q   <= 1'b0;
            chk_ok_q     <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < ALPHABET_LEN; i++)
                    lut_q[b][i] <= PORTLEN'(i ^ 1);
        end else begin
            chk_done_q <= 1'b0;
            if (in_acc) begin
                out_valid_q <= 1'b1;
                if (re_cs_n) begin
                    out_letter_q <= '0;
                    error_q      <= 1'b0;
                end else if (!BANK_OK[bank_sel] || !LETTER_OK[input_letter]) begin
                    out_letter_q <= '0;
                    error_q      <= 1'b1;
                end else begin
                    out_letter_q <= lut_rd(bank_sel, input_letter);
                    error_q      <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (prog_acc) begin
                        prg_bank_q <= prog_bank;
                        prg_a_q    <= prog_a;
                        prg_b_q    <= prog_b;
                    end else if (chk_go) begin
                        chk_bank_q <= chk_bank;
                        idx_q      <= '0;
                        fail_q     <= 1'b0;
                        chk_ok_q   <= 1'b0;
                    end
                end
                PRG_RD: begin
                    pa_q  <= lut_rd(prg_bank_q, prg_a_q);
                    pb_q  <= lut_rd(prg_bank_q, prg_b_q);
                    rej_q <= rej_d;
                end
                PRG_WR: begin
                    // Swapping both old partners together keeps the bank an involution.
                    if (!rej_q && (pa_q != prg_b_q)) begin
                        lut_q[prg_bank_q][prg_a_q] <= prg_b_q;
                        lut_q[prg_bank_q][prg_b_q] <= prg_a_q;
                        lut_q[prg_bank_q][pa_q]    <= pb_q;
                        lut_q[prg_bank_q][pb_q]    <= pa_q;
                    end
                end
                CHK: begin
                    fail_q <= fail_q || ent_fail;
                    if (last_idx) begin
                        chk_done_q <= 1'b1;
                        chk_ok_q   <= !(fail_q || ent_fail);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign output_letter = out_letter_q;
    assign error         = error_q;
    assign prog_err      = (state_q == PRG_WR) && rej_q;
    assign chk_busy      = (state_q == CHK);
    assign chk_done      = chk_done_q;
    assign chk_ok        = chk_ok_q;

endmodule
